d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop_pkg.sv | 14 +
 rtl/d_flip_flop.sv | 45 ++++
 tb/tb_d_flip_flop.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/d_flip_flop_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : d_flip_flop_pkg
//  Description : Shared defaults for the D-type storage element family.
//                DEFAULT_WIDTH is the single-bit primitive width used by
//                the lab designs when WIDTH is not overridden.
//  Revision    : 1.0  initial release
// ============================================================================
package d_flip_flop_pkg;

    localparam int C_DEFAULT_WIDTH = 1;

endpackage : d_flip_flop_pkg
`default_nettype wire

// File: rtl/d_flip_flop.sv
`default_nettype none
// ============================================================================
//  Module      : d_flip_flop
//  Description : Enable-gated rising-edge D register with synchronous
//                active-low reset and complementary outputs.
//  Ports       : clock   - system clock, all updates on rising edge
//                reset_n - synchronous active-low reset (dominates enable)
//                d       - data to store [WIDTH-1:0]
//                enable  - high: capture d at next edge, low: hold
//                q       - stored value [WIDTH-1:0]
//                q_n     - bitwise complement of q [WIDTH-1:0]
//  Revision    : 1.0  initial release
// ============================================================================
module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int                 WIDTH       = C_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [WIDTH-1:0]  d,
    input  logic              enable,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  q_n
);

    // Declaration initialiser gives the simulation power-up value; hardware
    // power-up state is undefined until the first reset edge.
    logic [WIDTH-1:0] r_q = RESET_VALUE;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_q <= RESET_VALUE;
        end else if (enable) begin
            r_q <= d;
        end
    end

    assign q   = r_q;
    // Derived from the single state register so q and q_n can never diverge.
    assign q_n = ~r_q;

endmodule : d_flip_flop
`default_nettype wire

// File: tb/tb_d_flip_flop.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_flip_flop
//  Description : Self-checking bench for d_flip_flop: a single-bit instance
//                and an 8-bit instance with a non-zero reset value, driven
//                by directed steps followed by randomized cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_d_flip_flop;

    localparam logic [7:0] C_RV8 = 8'hA5;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [0:0] d1 = '0;
    logic [7:0] d8 = '0;
    logic [0:0] q1, qn1;
    logic [7:0] q8, qn8;

    int checks = 0;
    int errors = 0;

    // Reference state, updated from the priority rules at each edge.
    logic       m1;
    logic [7:0] m8;

    always #5 clock = ~clock;

    d_flip_flop u_dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (d1),
        .enable  (enable),
        .q       (q1),
        .q_n     (qn1)
    );

    d_flip_flop #(.WIDTH(8), .RESET_VALUE(C_RV8)) u_dut8 (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (d8),
        .enable  (enable),
        .q       (q8),
        .q_n     (qn8)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q1"},   {7'd0, q1},  {7'd0, m1});
        check({tag, ".qn1"},  {7'd0, qn1}, {7'd0, ~m1});
        check({tag, ".q8"},   q8,  m8);
        check({tag, ".qn8"},  qn8, ~m8);
    endtask

    // One clock cycle: drive at the falling edge, apply the rules at the
    // rising edge, then sample 1 ns later.
    task automatic cyc(input logic rn, input logic en, input logic dv, input logic [7:0] dw,
                       input string tag);
        @(negedge clock);
        reset_n = rn;
        enable  = en;
        d1      = dv;
        d8      = dw;
        @(posedge clock);
        if (!rn) begin
            m1 = 1'b0;
            m8 = C_RV8;
        end else if (en) begin
            m1 = dv;
            m8 = dw;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        m1 = 1'b0;
        m8 = C_RV8;

        // Simulation power-up value, before any edge.
        #1;
        check_all("powerup");

        // Reset values.
        cyc(1'b0, 1'b1, 1'b1, 8'hFF, "reset_a");
        cyc(1'b0, 1'b0, 1'b0, 8'h00, "reset_b");

        // {enable,d} cycled 00,01,10,11.
        cyc(1'b1, 1'b0, 1'b0, 8'h3C, "ed00");
        cyc(1'b1, 1'b0, 1'b1, 8'hC3, "ed01");
        cyc(1'b1, 1'b1, 1'b0, 8'h5A, "ed10");
        cyc(1'b1, 1'b1, 1'b1, 8'h96, "ed11");

        // Hold while q=1, then load 0.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, "hold_hi_a");
        cyc(1'b1, 1'b0, 1'b1, 8'hFF, "hold_hi_b");
        cyc(1'b1, 1'b1, 1'b0, 8'h11, "load0");
        cyc(1'b1, 1'b1, 1'b1, 8'hE7, "load1");

        // Reset held 8 cycles while {enable,d} cycles twice.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, i[1], i[0], 8'($urandom), "rst_dom");
        end

        // Release reset mid-cycle with {enable,d}=11: nothing until the edge.
        @(negedge clock);
        enable = 1'b1;
        d1     = 1'b1;
        d8     = 8'h42;
        #2;
        reset_n = 1'b1;
        #1;
        check_all("rel_midcycle");
        @(posedge clock);
        m1 = 1'b1;
        m8 = 8'h42;
        #1;
        check_all("rel_edge");

        // Short reset pulse strictly between edges has no effect.
        cyc(1'b1, 1'b0, 1'b0, 8'h00, "pre_pulse");
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        check_all("pulse_low");
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_all("pulse_after");

        // Data/enable changes between edges are invisible on q.
        #2;
        enable = 1'b1;
        d1     = 1'b0;
        d8     = 8'h00;
        #1;
        check_all("no_comb_path");

        // Randomized cycles against the reference rules.
        for (int i = 0; i < 60; i++) begin
            cyc(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), 8'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_d_flip_flop
`default_nettype wire
